d_flip_flop: RTL and testbench



---
 rtl/d_flip_flop.sv | 31 +++
 tb/tb_d_flip_flop.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/d_flip_flop.sv
// Positive-edge D-type storage register with synchronous clear, load enable
// and a complementary output taken from the same storage element.
module d_flip_flop #(
  parameter int                 WIDTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  logic [WIDTH-1:0] q_p0;

  // Stage p0: the only storage; reset outranks the load enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_p0 <= RESET_VALUE;
    end else if (en) begin
      q_p0 <= d;
    end
  end

  // q_bar is a pure inversion of the stored value, so q and q_bar
  // never disagree.
  assign q     = q_p0;
  assign q_bar = ~q_p0;

endmodule

// File: tb/tb_d_flip_flop.sv
// Bench for d_flip_flop: a 1-bit default instance and an 8-bit instance with
// reset value 8'hA5, driven by a vector table, glitch sequences and random stimulus.
`timescale 1ns/1ps
module tb_d_flip_flop;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       d1;
  logic [7:0] d8;
  logic       q1, qb1;
  logic [7:0] q8, qb8;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] RV8 = 8'hA5;

  always #5 clk = ~clk;

  d_flip_flop u_bit (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .d     (d1),
    .q     (q1),
    .q_bar (qb1)
  );

  d_flip_flop #(.WIDTH(8), .RESET_VALUE(RV8)) u_byte (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .d     (d8),
    .q     (q8),
    .q_bar (qb8)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       d1;
    logic [7:0] d8;
    logic       glitch;
    logic       exp_q1;
    logic [7:0] exp_q8;
  } vec_t;

  vec_t vecs [15];

  // Reference state: what the specification says each register holds.
  logic       m_q1;
  logic [7:0] m_q8;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic e1, input logic [7:0] e8);
    chk({tag, " q1"},  {7'b0, q1},  {7'b0, e1});
    chk({tag, " qb1"}, {7'b0, qb1}, {7'b0, ~e1});
    chk({tag, " q8"},  q8,  e8);
    chk({tag, " qb8"}, qb8, ~e8);
  endtask

  // Drive inputs away from the edge, optionally wiggle d mid-cycle, then
  // sample 1 ns after the rising edge and advance the reference state.
  task automatic step(input logic r, input logic e, input logic v1,
                      input logic [7:0] v8, input logic glitch);
    rst = r; en = e; d1 = v1; d8 = v8;
    if (glitch) begin
      #1 d1 = ~v1; d8 = ~v8;
      chk("glitch hold q1", {7'b0, q1}, {7'b0, m_q1});
      chk("glitch hold q8", q8, m_q8);
      #1 d1 = v1;  d8 = v8;
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_q1 = 1'b0;
      m_q8 = RV8;
    end else if (e) begin
      m_q1 = v1;
      m_q8 = v8;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //         rst   en    d1    d8     gl    q1    q8
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h81, 1'b0, 1'b0, 8'h81};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1, 8'h7E};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h7E};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h7E};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h7E};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h11};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 8'h22};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 8'hA5};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 8'hA5};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 8'hA5};

    m_q1 = 1'bx;
    m_q8 = 8'hxx;

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].d1, vecs[i].d8, vecs[i].glitch);
      check_all($sformatf("vec%0d", i), vecs[i].exp_q1, vecs[i].exp_q8);
    end

    // Reset held over several edges keeps the reset value regardless of d.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'(i), 8'(i * 37 + 5), 1'b0);
      check_all("rst hold", 1'b0, RV8);
    end

    // First enabled edge after reset release captures.
    step(1'b0, 1'b1, 1'b1, 8'hC3, 1'b0);
    check_all("rst release", 1'b1, 8'hC3);

    // Randomised traffic against the reference state.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(7) == 0), ($urandom_range(2) != 0),
           1'($urandom), 8'($urandom), ($urandom_range(9) == 0));
      check_all("rand", m_q1, m_q8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
